// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared defaults, configuration struct and clamp helper for the programmable divider
package clk_div_pkg;

    localparam int CNT_W_DEF   = 16;
    localparam int DEF_DIV_DEF = 2;
    // Configuration fields are carried at a fixed 32-bit width so the struct
    // does not depend on the divider's CNT_W parameter.
    localparam int CFG_W       = 32;

    typedef struct packed {
        logic [CFG_W-1:0] n;
        logic [CFG_W-1:0] h;
    } cfg_t;

    // Period below 2 cannot toggle, and high time can never exceed the period.
    function automatic cfg_t clamp_cfg(input logic [CFG_W-1:0] n, input logic [CFG_W-1:0] h);
        cfg_t c;
        c.n = (n < CFG_W'(2)) ? CFG_W'(2) : n;
        c.h = (h > c.n) ? c.n : h;
        return c;
    endfunction

endpackage

// File: rtl/clk_div_prog_if.sv
// rtl/clk_div_prog_if.sv - control and status bundle of the programmable divider
interface clk_div_prog_if #(
    parameter int CNT_W = clk_div_pkg::CNT_W_DEF
) ();

    logic             en;
    logic             load;
    logic [CNT_W-1:0] div_in;
    logic [CNT_W-1:0] high_in;
    logic             out_clk;
    logic             tick;
    logic             pend;
    logic             load_ack;

    modport master (
        output en, load, div_in, high_in,
        input  out_clk, tick, pend, load_ack
    );

    modport slave (
        input  en, load, div_in, high_in,
        output out_clk, tick, pend, load_ack
    );

endinterface

// File: rtl/clk_div_cfg.sv
// rtl/clk_div_cfg.sv - shadow configuration, pending flag, period-boundary apply and load acknowledge
module clk_div_cfg
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DEF_DIV = DEF_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] div_in,
    input  logic [CNT_W-1:0] high_in,
    input  logic             wrap,
    output logic [CFG_W-1:0] cur_n,
    output logic [CFG_W-1:0] next_h,
    output logic             pend,
    output logic             load_ack
);

    localparam cfg_t DEF_CFG = '{n: CFG_W'(DEF_DIV), h: CFG_W'(DEF_DIV / 2)};

    cfg_t cur_q, cur_d;
    cfg_t shd_q, shd_d;
    logic pend_q, pend_d;
    logic ack_q, ack_d;
    cfg_t req;

    assign req = clamp_cfg(CFG_W'(div_in), CFG_W'(high_in));

    always_comb begin
        cur_d  = cur_q;
        shd_d  = shd_q;
        pend_d = pend_q;
        ack_d  = 1'b0;
        if (!en) begin
            // Idle: nothing is being generated, so a load applies at once.
            // A pending value survives idle and applies when the next run starts.
            if (load) begin
                cur_d  = req;
                pend_d = 1'b0;
                ack_d  = 1'b1;
            end
        end else if (wrap) begin
            // A load arriving on the boundary edge goes straight into the new
            // period and supersedes anything still pending.
            if (load) begin
                cur_d  = req;
                pend_d = 1'b0;
                ack_d  = 1'b1;
            end else if (pend_q) begin
                cur_d  = shd_q;
                pend_d = 1'b0;
                ack_d  = 1'b1;
            end
        end else if (load) begin
            shd_d  = req;
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q  <= DEF_CFG;
            shd_q  <= DEF_CFG;
            pend_q <= 1'b0;
            ack_q  <= 1'b0;
        end else begin
            cur_q  <= cur_d;
            shd_q  <= shd_d;
            pend_q <= pend_d;
            ack_q  <= ack_d;
        end
    end

    assign cur_n    = cur_q.n;
    assign next_h   = cur_d.h;
    assign pend     = pend_q;
    assign load_ack = ack_q;

endmodule

// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - programmable clock divider with glitch-free period-boundary reconfiguration
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DEF_DIV = DEF_DIV_DEF
) (
    input  logic           clk,
    input  logic           rst,
    clk_div_prog_if.slave  bus
);

    logic             rst_meta_q, rst_sync_q;
    logic             run_q, run_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             tick_q, tick_d;
    logic [CFG_W-1:0] cur_n;
    logic [CFG_W-1:0] next_h;
    logic             wrap;

    // Assert asynchronously, release two edges later so no flop sees the
    // release close to a clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    // A period starts on the first running edge after idle or after the last count.
    assign wrap = !run_q || (CFG_W'(cnt_q) == cur_n - CFG_W'(1));

    clk_div_cfg #(
        .CNT_W   (CNT_W),
        .DEF_DIV (DEF_DIV)
    ) u_cfg (
        .clk      (clk),
        .rst_n    (rst_sync_q),
        .en       (bus.en),
        .load     (bus.load),
        .div_in   (bus.div_in),
        .high_in  (bus.high_in),
        .wrap     (wrap),
        .cur_n    (cur_n),
        .next_h   (next_h),
        .pend     (bus.pend),
        .load_ack (bus.load_ack)
    );

    always_comb begin
        run_d  = 1'b0;
        cnt_d  = '0;
        out_d  = 1'b0;
        tick_d = 1'b0;
        if (bus.en) begin
            run_d  = 1'b1;
            tick_d = wrap;
            cnt_d  = wrap ? '0 : cnt_q + CNT_W'(1);
            // Compare against the high time that will be active after this
            // edge so a newly applied configuration shapes its first period.
            out_d  = CFG_W'(cnt_d) < next_h;
        end
    end

    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            run_q  <= 1'b0;
            cnt_q  <= '0;
            out_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            run_q  <= run_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            tick_q <= tick_d;
        end
    end

    assign bus.out_clk = out_q;
    assign bus.tick    = tick_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// tb/tb_clk_div_prog.sv - scoreboard bench for clk_div_prog against a cycle-level reference model
module tb_clk_div_prog;

    logic clk = 1'b1;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    clk_div_prog_if #(.CNT_W(16)) bus ();

    clk_div_prog #(.CNT_W(16), .DEF_DIV(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    logic [3:0] exp_q[$];
    bit active = 1'b0;
    logic [3:0] e_v, a_v;

    // Reference state: active period/high time, pending config, position in period.
    int m_n = 2, m_h = 1, p_n = 0, p_h = 0, m_pos = 0;
    bit p_v = 1'b0, m_run = 1'b0;

    function automatic void model_reset();
        m_n = 2; m_h = 1; p_v = 1'b0; m_run = 1'b0; m_pos = 0;
    endfunction

    // Returns {out_clk, tick, pend, load_ack} expected after the coming edge.
    function automatic logic [3:0] model_step(bit en, bit load, int dn, int dh);
        int cn, ch;
        bit ack, o, t;
        ack = 1'b0;
        cn = (dn < 2) ? 2 : dn;
        ch = (dh > cn) ? cn : dh;
        if (!en) begin
            if (load) begin m_n = cn; m_h = ch; p_v = 1'b0; ack = 1'b1; end
            m_run = 1'b0; m_pos = 0; o = 1'b0; t = 1'b0;
        end else begin
            if (!m_run || m_pos == m_n - 1) begin
                if (load) begin m_n = cn; m_h = ch; p_v = 1'b0; ack = 1'b1; end
                else if (p_v) begin m_n = p_n; m_h = p_h; p_v = 1'b0; ack = 1'b1; end
                m_pos = 0;
            end else begin
                m_pos = m_pos + 1;
                if (load) begin p_n = cn; p_h = ch; p_v = 1'b1; end
            end
            m_run = 1'b1;
            o = (m_pos < m_h);
            t = (m_pos == 0);
        end
        return {o, t, p_v, ack};
    endfunction

    task automatic cycle(bit en, bit load, int dn, int dh);
        @(negedge clk);
        bus.en      = en;
        bus.load    = load;
        bus.div_in  = 16'(dn);
        bus.high_in = 16'(dh);
        exp_q.push_back(model_step(en, load, dn, dh));
        active = 1'b1;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 0, 0);
    endtask

    task automatic hold_reset_and_release();
        cycle(1'b0, 1'b0, 0, 0);
        cycle(1'b0, 1'b0, 0, 0);
        #2 rst = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 0, 0);
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        n_chk++;
        if ({bus.out_clk, bus.tick, bus.pend, bus.load_ack} !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_reset outputs got %b expected 0000", {bus.out_clk, bus.tick, bus.pend, bus.load_ack});
        end
        model_reset();
        hold_reset_and_release();
    endtask

    always @(posedge clk) begin
        #1;
        if (active) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty at %0t got nothing expected an entry", $time);
            end else begin
                e_v = exp_q.pop_front();
                a_v = {bus.out_clk, bus.tick, bus.pend, bus.load_ack};
                if (a_v !== e_v) begin
                    n_fail++;
                    $display("FAIL cycle_outputs at %0t {out_clk,tick,pend,load_ack} got %b expected %b", $time, a_v, e_v);
                end
            end
        end
    end

    initial begin
        bus.en = 1'b0; bus.load = 1'b0; bus.div_in = '0; bus.high_in = '0;
        #1 rst = 1'b0;
        hold_reset_and_release();

        run(8);                                 // defaults: divide by 2

        cycle(1'b0, 1'b0, 0, 0);                // idle load 5/2 then run
        cycle(1'b0, 1'b1, 5, 2);
        cycle(1'b0, 1'b0, 0, 0);
        run(12);

        cycle(1'b0, 1'b1, 4, 2);                // run 4/2, load 6/3 mid-period
        run(2);
        cycle(1'b1, 1'b1, 6, 3);
        run(14);

        run(2);                                 // two loads in one period, last wins
        cycle(1'b1, 1'b1, 3, 1);
        cycle(1'b1, 1'b1, 7, 2);
        run(16);

        cycle(1'b1, 1'b1, 0, 0);                // clamps: N=2 held low, then N=4 held high
        run(8);
        cycle(1'b1, 1'b1, 4, 9);
        run(12);

        cycle(1'b0, 1'b1, 3, 1);                // load coincident with en falling
        cycle(1'b0, 1'b0, 0, 0);
        run(7);

        cycle(1'b1, 1'b1, 6, 3);                // reset with a pending config
        async_reset();
        run(6);

        for (int i = 0; i < 1500; i++) begin
            if (i == 700) async_reset();
            cycle($urandom_range(0, 19) != 0, $urandom_range(0, 7) == 0,
                  int'($urandom_range(0, 9)), int'($urandom_range(0, 11)));
        end

        @(posedge clk);
        #2 active = 1'b0;
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d entries left expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
